// File: rtl/taus_combined_gen.sv
// taus_combined_gen: three-component combined Tausworthe generator (taus88 form)
// with runtime reseed, post-seed warm-up discard and valid/ready output.
`default_nettype none

module taus_combined_gen #(
    parameter logic [31:0] SEED1  = 32'd12345,
    parameter logic [31:0] SEED2  = 32'd12345,
    parameter logic [31:0] SEED3  = 32'd12345,
    parameter logic [31:0] C1     = 32'hFFFFFFFE,
    parameter logic [31:0] C2     = 32'hFFFFFFF8,
    parameter logic [31:0] C3     = 32'hFFFFFFF0,
    parameter int          Q1     = 13,
    parameter int          Q2     = 2,
    parameter int          Q3     = 3,
    parameter int          R1     = 19,
    parameter int          R2     = 25,
    parameter int          R3     = 11,
    parameter int          S1     = 12,
    parameter int          S2     = 4,
    parameter int          S3     = 17,
    parameter logic [31:0] MIN1   = 32'd2,
    parameter logic [31:0] MIN2   = 32'd8,
    parameter logic [31:0] MIN3   = 32'd16,
    parameter int          WARMUP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [31:0] seed1,
    input  logic [31:0] seed2,
    input  logic [31:0] seed3,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        warming
);

    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WARMUP > 0) ? (WARMUP - 1) : 0);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam state_t ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    function automatic logic [31:0] taus_step(
        input logic [31:0] s,
        input logic [31:0] c,
        input int          q,
        input int          r,
        input int          sh
    );
        logic [31:0] fb;
        fb = ((s << q) ^ s) >> r;
        return ((s & c) << sh) ^ fb;
    endfunction

    // Seeds below the component minimum would lock up or degrade; offset them.
    function automatic logic [31:0] sanitise(input logic [31:0] seed, input logic [31:0] min);
        return (seed < min) ? (seed + min) : seed;
    endfunction

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   s1_q, s2_q, s3_q;
    logic [31:0]   s1_d, s2_d, s3_d;
    logic          valid_q;
    logic          warming_q;

    assign s1_d = taus_step(s1_q, C1, Q1, R1, S1);
    assign s2_d = taus_step(s2_q, C2, Q2, R2, S2);
    assign s3_d = taus_step(s3_q, C3, Q3, R3, S3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= sanitise(SEED1, MIN1);
            s2_q      <= sanitise(SEED2, MIN2);
            s3_q      <= sanitise(SEED3, MIN3);
            cnt_q     <= '0;
            state_q   <= ST_INIT;
            valid_q   <= 1'b0;
            warming_q <= (WARMUP != 0);
        end else if (seed_load) begin
            s1_q      <= sanitise(seed1, MIN1);
            s2_q      <= sanitise(seed2, MIN2);
            s3_q      <= sanitise(seed3, MIN3);
            cnt_q     <= '0;
            state_q   <= ST_INIT;
            valid_q   <= (WARMUP == 0);
            warming_q <= (WARMUP != 0);
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    s1_q <= s1_d;
                    s2_q <= s2_d;
                    s3_q <= s3_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        state_q   <= ST_RUN;
                        valid_q   <= 1'b1;
                        warming_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // valid_q trails state by one edge only right after a WARMUP=0 reset.
                    valid_q   <= 1'b1;
                    warming_q <= 1'b0;
                    if (valid_q && out_ready) begin
                        s1_q <= s1_d;
                        s2_q <= s2_d;
                        s3_q <= s3_d;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign warming   = warming_q;
    assign out_data  = s1_q ^ s2_q ^ s3_q;

endmodule

`default_nettype wire

// File: tb/tb_taus_combined_gen.sv
// tb_taus_combined_gen: directed checks of taus_combined_gen with WARMUP=0 and WARMUP=8.
`default_nettype none

module tb_taus_combined_gen;

    logic clk;
    int   checks;
    int   failures;

    // Instance A: WARMUP=0
    logic        a_rst, a_load, a_ready, a_valid, a_warming;
    logic [31:0] a_s1, a_s2, a_s3, a_data;
    // Instance B: WARMUP=8
    logic        b_rst, b_load, b_ready, b_valid, b_warming;
    logic [31:0] b_s1, b_s2, b_s3, b_data;

    logic [31:0] m1, m2, m3;

    taus_combined_gen #(.WARMUP(0)) dut_a (
        .clk(clk), .rst(a_rst), .seed_load(a_load),
        .seed1(a_s1), .seed2(a_s2), .seed3(a_s3),
        .out_ready(a_ready), .out_valid(a_valid), .out_data(a_data), .warming(a_warming)
    );

    taus_combined_gen #(.WARMUP(8)) dut_b (
        .clk(clk), .rst(b_rst), .seed_load(b_load),
        .seed1(b_s1), .seed2(b_s2), .seed3(b_s3),
        .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data), .warming(b_warming)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] comp(input logic [31:0] s, input logic [31:0] c,
                                         input int q, input int r, input int k);
        logic [31:0] t;
        logic [31:0] b;
        t = s << q;
        t = t ^ s;
        b = t >> r;
        t = s & c;
        t = t << k;
        return t ^ b;
    endfunction

    task automatic model_step();
        m1 = comp(m1, 32'hFFFFFFFE, 13, 19, 12);
        m2 = comp(m2, 32'hFFFFFFF8, 2, 25, 4);
        m3 = comp(m3, 32'hFFFFFFF0, 3, 11, 17);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid actual=%b expected=0", a_valid); end
        checks++;
        if (a_data !== 32'h00003039) begin failures++; $display("FAIL reset_a_data actual=%h expected=00003039", a_data); end
        checks++;
        if (a_warming !== 1'b0) begin failures++; $display("FAIL reset_a_warming actual=%b expected=0", a_warming); end
        checks++;
        if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid actual=%b expected=0", b_valid); end
        checks++;
        if (b_warming !== 1'b1) begin failures++; $display("FAIL reset_b_warming actual=%b expected=1", b_warming); end
    endtask

    task automatic test_warmup0_hold();
        a_ready = 1'b0;
        a_rst   = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (a_valid !== 1'b1 || a_data !== 32'h00003039) begin
                failures++;
                $display("FAIL hold_w0 cyc=%0d actual valid=%b data=%h expected valid=1 data=00003039", i, a_valid, a_data);
            end
            tick();
        end
    endtask

    task automatic test_seed_zero();
        a_s1 = 32'd0; a_s2 = 32'd0; a_s3 = 32'd0;
        a_load = 1'b1;
        tick();
        a_load = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 32'h0000001A) begin
            failures++;
            $display("FAIL seed_zero_first actual valid=%b data=%h expected valid=1 data=0000001a", a_valid, a_data);
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        checks++;
        if (a_data !== 32'h00202080) begin
            failures++;
            $display("FAIL seed_zero_second actual=%h expected=00202080", a_data);
        end
        tick();
        checks++;
        if (a_data !== 32'h00202080) begin
            failures++;
            $display("FAIL seed_zero_hold actual=%h expected=00202080", a_data);
        end
    endtask

    task automatic test_back_to_back();
        m1 = 32'd2; m2 = 32'd8; m3 = 32'd16;
        model_step();
        a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            model_step();
            checks++;
            if (a_data !== (m1 ^ m2 ^ m3)) begin
                failures++;
                $display("FAIL b2b_w0 idx=%0d actual=%h expected=%h", i, a_data, m1 ^ m2 ^ m3);
            end
        end
        a_ready = 1'b0;
    endtask

    // Entered with b_rst asserted; releases it and checks the warm-up window.
    task automatic test_warmup8();
        b_ready = 1'b0;
        b_rst   = 1'b0;
        m1 = 32'd12345; m2 = 32'd12345; m3 = 32'd12345;
        for (int i = 0; i < 8; i++) model_step();
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (b_valid !== 1'b0 || b_warming !== 1'b1) begin
                failures++;
                $display("FAIL warmup_cycle%0d actual valid=%b warming=%b expected valid=0 warming=1", i, b_valid, b_warming);
            end
            tick();
        end
        checks++;
        if (b_valid !== 1'b1 || b_warming !== 1'b0) begin
            failures++;
            $display("FAIL warmup_cycle9 actual valid=%b warming=%b expected valid=1 warming=0", b_valid, b_warming);
        end
        checks++;
        if (b_data !== (m1 ^ m2 ^ m3)) begin
            failures++;
            $display("FAIL warmup_first_word actual=%h expected=%h", b_data, m1 ^ m2 ^ m3);
        end
    endtask

    task automatic test_ready_pattern();
        logic [4:0] pat;
        pat = 5'b11001;
        for (int i = 4; i >= 0; i--) begin
            b_ready = pat[i];
            tick();
            if (pat[i]) model_step();
            checks++;
            if (b_valid !== 1'b1 || b_data !== (m1 ^ m2 ^ m3)) begin
                failures++;
                $display("FAIL ready_pat step=%0d actual valid=%b data=%h expected valid=1 data=%h", 4 - i, b_valid, b_data, m1 ^ m2 ^ m3);
            end
        end
        b_ready = 1'b0;
    endtask

    task automatic test_reload_on_transfer();
        b_s1 = 32'd1; b_s2 = 32'd8; b_s3 = 32'd15;
        b_ready = 1'b1;
        b_load  = 1'b1;
        tick();
        b_load  = 1'b0;
        b_ready = 1'b0;
        checks++;
        if (b_valid !== 1'b0 || b_warming !== 1'b1) begin
            failures++;
            $display("FAIL reload_flags actual valid=%b warming=%b expected valid=0 warming=1", b_valid, b_warming);
        end
        // Sanitised seeds 3, 8, 31 give 3^8^31 = 0x14.
        checks++;
        if (b_data !== 32'h00000014) begin
            failures++;
            $display("FAIL reload_seed_word actual=%h expected=00000014", b_data);
        end
        m1 = 32'd3; m2 = 32'd8; m3 = 32'd31;
        for (int i = 0; i < 8; i++) model_step();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (b_valid !== 1'b0) begin
                failures++;
                $display("FAIL reload_warm idx=%0d actual valid=%b expected valid=0", i, b_valid);
            end
        end
        tick();
        checks++;
        if (b_valid !== 1'b1 || b_data !== (m1 ^ m2 ^ m3)) begin
            failures++;
            $display("FAIL reload_first_word actual valid=%b data=%h expected valid=1 data=%h", b_valid, b_data, m1 ^ m2 ^ m3);
        end
    endtask

    task automatic test_random_ready();
        logic r;
        for (int i = 0; i < 300; i++) begin
            r = 1'($urandom_range(0, 1));
            b_ready = r;
            tick();
            if (r) model_step();
            checks++;
            if (b_valid !== 1'b1 || b_data !== (m1 ^ m2 ^ m3)) begin
                failures++;
                $display("FAIL random idx=%0d actual valid=%b data=%h expected valid=1 data=%h", i, b_valid, b_data, m1 ^ m2 ^ m3);
            end
        end
        b_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        b_ready = 1'b1;
        tick();
        #3;
        b_rst = 1'b1;
        #1;
        checks++;
        if (b_valid !== 1'b0 || b_warming !== 1'b1 || b_data !== 32'h00003039) begin
            failures++;
            $display("FAIL async_rst_run actual valid=%b warming=%b data=%h expected valid=0 warming=1 data=00003039", b_valid, b_warming, b_data);
        end
        b_ready = 1'b0;
        tick();
        // Release, get partway into warm-up, then reset off-edge again.
        b_rst = 1'b0;
        tick();
        tick();
        tick();
        #2;
        b_rst = 1'b1;
        #1;
        checks++;
        if (b_valid !== 1'b0 || b_data !== 32'h00003039) begin
            failures++;
            $display("FAIL async_rst_warm actual valid=%b data=%h expected valid=0 data=00003039", b_valid, b_data);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        a_rst = 1'b1; a_load = 1'b0; a_ready = 1'b0;
        a_s1 = '0; a_s2 = '0; a_s3 = '0;
        b_rst = 1'b1; b_load = 1'b0; b_ready = 1'b0;
        b_s1 = '0; b_s2 = '0; b_s3 = '0;

        test_reset();
        tick();
        test_warmup0_hold();
        test_seed_zero();
        test_back_to_back();
        test_warmup8();
        test_ready_pattern();
        test_reload_on_transfer();
        test_random_ready();
        test_async_reset();
        test_warmup8();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
